// File: rtl/straight_scanner_seq.sv
// rtl/straight_scanner_seq.sv - streaming poker straight detector with sequential window scan
module straight_scanner_seq #(
    parameter int HAND_SIZE   = 5,
    parameter int RUN_LEN     = 5,
    parameter int ACE_HIGH_EN = 1,
    localparam int NUM_WIN    = 15 - RUN_LEN,
    localparam int CNT_W      = $clog2(HAND_SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_rank,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               is_straight,
    output logic [NUM_WIN-1:0] straight_mask,
    output logic [3:0]         top_rank,
    output logic [CNT_W-1:0]   card_count,
    output logic               err_rank
);

    localparam int IDX_W = $clog2(NUM_WIN + 1);
    localparam logic [13:0] RUN_MASK = {{(14 - RUN_LEN){1'b0}}, {RUN_LEN{1'b1}}};
    localparam logic [NUM_WIN-1:0] WIN_ONE = {{(NUM_WIN - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_SCAN    = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [13:0]        pm;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [NUM_WIN-1:0] mask_r;
    logic [3:0]         top_r;
    logic               err_r;
    logic               ov_r;

    logic               accept;
    logic               rank_legal;
    logic [13:0]        rank_bits;
    logic               hand_end;
    logic               scan_last;
    logic               pop;
    logic [13:0]        window;
    logic               hit;

    assign accept     = in_valid & in_ready;
    assign rank_legal = (in_rank >= 4'd1) && (in_rank <= 4'd13);
    assign cnt_inc    = cnt + CNT_W'(1);
    assign hand_end   = accept & (in_last | (cnt_inc == CNT_W'(HAND_SIZE)));
    assign scan_last  = (idx == IDX_W'(NUM_WIN - 1));
    assign pop        = ov_r & out_ready;
    assign window     = pm >> idx;
    assign hit        = ((window & RUN_MASK) == RUN_MASK);

    // Ace lands in both the lowest and (optionally) the highest mask slot.
    always_comb begin
        rank_bits = '0;
        if (rank_legal) begin
            rank_bits = 14'd1 << (in_rank - 4'd1);
            if ((ACE_HIGH_EN != 0) && (in_rank == 4'd1)) begin
                rank_bits[13] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: if (hand_end)  state_nxt = S_SCAN;
            S_SCAN:    if (scan_last) state_nxt = S_DONE;
            S_DONE:    if (pop)       state_nxt = S_COLLECT;
            default:                  state_nxt = S_COLLECT;
        endcase
    end

    always_comb begin
        in_ready = (state == S_COLLECT);
    end

    // out_valid rises one cycle into DONE so every result register has settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm     <= '0;
            idx    <= '0;
            cnt    <= '0;
            mask_r <= '0;
            top_r  <= '0;
            err_r  <= 1'b0;
            ov_r   <= 1'b0;
        end else begin
            case (state)
                S_COLLECT: begin
                    idx <= '0;
                    if (accept) begin
                        cnt <= cnt_inc;
                        if (rank_legal) begin
                            pm <= pm | rank_bits;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    idx <= idx + IDX_W'(1);
                    if (hit) begin
                        mask_r <= mask_r | (WIN_ONE << idx);
                        top_r  <= 4'(idx) + 4'(RUN_LEN);
                    end
                end
                S_DONE: begin
                    if (pop) begin
                        pm     <= '0;
                        cnt    <= '0;
                        mask_r <= '0;
                        top_r  <= '0;
                        err_r  <= 1'b0;
                        ov_r   <= 1'b0;
                    end else begin
                        ov_r <= 1'b1;
                    end
                end
                default: begin
                    ov_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid     = ov_r;
    assign is_straight   = |mask_r;
    assign straight_mask = mask_r;
    assign top_rank      = top_r;
    assign card_count    = cnt;
    assign err_rank      = err_r;

endmodule

// File: tb/tb_straight_scanner_seq.sv
// tb/tb_straight_scanner_seq.sv - directed bench for straight_scanner_seq (default, ace-low, 7-card builds)
module tb_straight_scanner_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_rank;
    logic       out_ready;
    logic       iv    [3];
    logic       il    [3];
    logic       ir    [3];
    logic       ov    [3];
    logic       ist   [3];
    logic [9:0] smask [3];
    logic [3:0] top   [3];
    logic [2:0] cnt   [3];
    logic       err   [3];

    int n_checks;
    int n_fail;

    straight_scanner_seq #(.HAND_SIZE(5), .RUN_LEN(5), .ACE_HIGH_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_rank(in_rank),
        .in_last(il[0]), .out_valid(ov[0]), .out_ready(out_ready), .is_straight(ist[0]),
        .straight_mask(smask[0]), .top_rank(top[0]), .card_count(cnt[0]), .err_rank(err[0])
    );

    straight_scanner_seq #(.HAND_SIZE(5), .RUN_LEN(5), .ACE_HIGH_EN(0)) dut_noace (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_rank(in_rank),
        .in_last(il[1]), .out_valid(ov[1]), .out_ready(out_ready), .is_straight(ist[1]),
        .straight_mask(smask[1]), .top_rank(top[1]), .card_count(cnt[1]), .err_rank(err[1])
    );

    straight_scanner_seq #(.HAND_SIZE(7), .RUN_LEN(5), .ACE_HIGH_EN(1)) dut_h7 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_rank(in_rank),
        .in_last(il[2]), .out_valid(ov[2]), .out_ready(out_ready), .is_straight(ist[2]),
        .straight_mask(smask[2]), .top_rank(top[2]), .card_count(cnt[2]), .err_rank(err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cards are packed low nibble first; in_last marks the n-th card when use_last is set.
    task automatic send_hand(input int s, input int n, input logic [63:0] cv, input bit use_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            iv[s]   = 1'b1;
            in_rank = cv[4*i +: 4];
            il[s]   = use_last && (i == n - 1);
        end
        @(posedge clk);
        #1;
        iv[s] = 1'b0;
        il[s] = 1'b0;
    endtask

    task automatic wait_result(input int s, input string tag);
        int lat;
        lat = 0;
        while (!ov[s] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ".latency"}, lat, 11);
    endtask

    task automatic check_result(input int s, input string tag, input logic [9:0] e_mask,
                                input logic [3:0] e_top, input logic [2:0] e_cnt, input logic e_err);
        check_eq({tag, ".mask"}, {22'd0, smask[s]}, {22'd0, e_mask});
        check_eq({tag, ".is_straight"}, {31'd0, ist[s]}, {31'd0, |e_mask});
        check_eq({tag, ".top_rank"}, {28'd0, top[s]}, {28'd0, e_top});
        check_eq({tag, ".card_count"}, {29'd0, cnt[s]}, {29'd0, e_cnt});
        check_eq({tag, ".err_rank"}, {31'd0, err[s]}, {31'd0, e_err});
    endtask

    task automatic pop_result(input int s, input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, ".pop_out_valid"}, {31'd0, ov[s]}, 32'd0);
        check_eq({tag, ".pop_in_ready"}, {31'd0, ir[s]}, 32'd1);
    endtask

    task automatic run_hand(input int s, input string tag, input int n, input logic [63:0] cv,
                            input bit use_last, input logic [9:0] e_mask, input logic [3:0] e_top,
                            input logic [2:0] e_cnt, input logic e_err);
        send_hand(s, n, cv, use_last);
        wait_result(s, tag);
        check_result(s, tag, e_mask, e_top, e_cnt, e_err);
        pop_result(s, tag);
    endtask

    initial begin
        logic [22:0] snap;
        bit          stable;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_rank   = 4'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            il[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("reset.in_ready%0d", i), {31'd0, ir[i]}, 32'd1);
            check_eq($sformatf("reset.out_valid%0d", i), {31'd0, ov[i]}, 32'd0);
        end
        check_eq("reset.mask", {22'd0, smask[0]}, 32'd0);
        check_eq("reset.card_count", {29'd0, cnt[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_hand(0, "t1", 5, 64'h98567, 1'b1, 10'b0000010000, 4'd9, 3'd5, 1'b0);
        run_hand(0, "t2.ace", 5, 64'hADCB1, 1'b1, 10'b1000000000, 4'd14, 3'd5, 1'b0);
        run_hand(1, "t2.noace", 5, 64'hADCB1, 1'b1, 10'b0000000000, 4'd0, 3'd5, 1'b0);
        run_hand(0, "t3.bad", 5, 64'h0C174, 1'b1, 10'b0000000000, 4'd0, 3'd5, 1'b1);
        run_hand(0, "t3.next", 5, 64'h65432, 1'b1, 10'b0000000010, 4'd6, 3'd5, 1'b0);
        run_hand(2, "t4", 7, 64'h6654321, 1'b0, 10'b0000000011, 4'd6, 3'd7, 1'b0);

        send_hand(0, 3, 64'h432, 1'b1);
        wait_result(0, "t5");
        check_result(0, "t5", 10'b0, 4'd0, 3'd3, 1'b0);
        snap   = {ov[0], ir[0], ist[0], smask[0], top[0], cnt[0], err[0]};
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if ({ov[0], ir[0], ist[0], smask[0], top[0], cnt[0], err[0]} !== snap) stable = 1'b0;
        end
        check_eq("t5.stable", {31'd0, stable}, 32'd1);
        check_eq("t5.hold_in_ready", {31'd0, ir[0]}, 32'd0);
        pop_result(0, "t5");

        send_hand(0, 5, 64'h98765, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("t6.scanning", {31'd0, ir[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("t6.rst_out_valid", {31'd0, ov[0]}, 32'd0);
        check_eq("t6.rst_in_ready", {31'd0, ir[0]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_eq("t6.no_result", {31'd0, ov[0]}, 32'd0);
        run_hand(0, "t6.after", 5, 64'h98765, 1'b1, 10'b0000010000, 4'd9, 3'd5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
